mux_rr_nto1: RTL

- Parametrised, registered N-to-1 channel multiplexer with per-channel valid/ready handshake.
- Arbitrates between CHANNELS requesters using round-robin or fixed priority, or an explicit select override that behaves like a plain select mux.
- Registers the winning word into a single-entry output stage.
- Used in the pipelined datapath wherever several producers share one consumer, e.g. writeback or memory-request merge points.

---
 rtl/mux_rr_nto1_if.sv | 30 +++
 rtl/mux_rr_nto1.sv | 101 ++++++++++
 2 files changed

// File: rtl/mux_rr_nto1_if.sv
// Handshake bundle for the N-to-1 channel multiplexer.
// Producers drive the valid_i/data_i side and the consumer drives ready_i.
// The mux owns ready_o and the registered output.
interface mux_rr_nto1_if #(
  parameter int unsigned size     = 32,
  parameter int unsigned CHANNELS = 4,
  parameter int unsigned SELW     = 2
);
  logic [CHANNELS-1:0]      valid_i;
  logic [CHANNELS*size-1:0] data_i;
  logic [CHANNELS-1:0]      ready_o;
  logic                     force_en_i;
  logic [SELW-1:0]          force_sel_i;
  logic [size-1:0]          data_o;
  logic                     valid_o;
  logic [SELW-1:0]          sel_o;
  logic                     ready_i;

  // Producer/consumer side (drives requests and downstream ready)
  modport master (
    output valid_i, data_i, force_en_i, force_sel_i, ready_i,
    input  ready_o, data_o, valid_o, sel_o
  );

  // Multiplexer side
  modport slave (
    input  valid_i, data_i, force_en_i, force_sel_i, ready_i,
    output ready_o, data_o, valid_o, sel_o
  );
endinterface

// File: rtl/mux_rr_nto1.sv
// Registered N-to-1 channel multiplexer.
// Picks one requesting channel per cycle (round-robin, fixed priority or forced select)
// and registers the winning word into a single-entry output stage.
module mux_rr_nto1 #(
  parameter int unsigned size     = 32,
  parameter int unsigned CHANNELS = 4,
  parameter int unsigned SELW     = 2,
  parameter int unsigned MODE     = 0   // 0 = round-robin, 1 = fixed priority
) (
  input logic          clk_i,
  input logic          rst_i,   // asynchronous, active low
  mux_rr_nto1_if.slave bus
);

  logic [SELW-1:0]     ptr_q;
  logic [SELW-1:0]     sel_q;
  logic [size-1:0]     data_q;
  logic                valid_q;

  logic                load;
  logic                has_grant;
  logic                xfer;
  logic [SELW-1:0]     gidx;
  logic [SELW-1:0]     ptr_nxt;
  logic [CHANNELS-1:0] grant;
  logic [size-1:0]     win_data;
  int unsigned         j;

  // Output stage can take a word when empty or draining this cycle
  assign load = ~valid_q | bus.ready_i;

  // Arbitration: pick the granted channel index from current requests and pointer
  always_comb begin
    has_grant = 1'b0;
    gidx      = '0;
    j         = 0;
    if (bus.force_en_i) begin
      // Out-of-range forced index yields no grant
      if (32'(bus.force_sel_i) < CHANNELS) begin
        if (bus.valid_i[bus.force_sel_i]) begin
          has_grant = 1'b1;
          gidx      = bus.force_sel_i;
        end
      end
    end else if (MODE == 0) begin
      for (int unsigned i = 0; i < CHANNELS; i++) begin
        j = 32'(ptr_q) + i;
        if (j >= CHANNELS) j = j - CHANNELS;
        if (!has_grant && bus.valid_i[SELW'(j)]) begin
          has_grant = 1'b1;
          gidx      = SELW'(j);
        end
      end
    end else begin
      for (int unsigned i = 0; i < CHANNELS; i++) begin
        if (!has_grant && bus.valid_i[SELW'(i)]) begin
          has_grant = 1'b1;
          gidx      = SELW'(i);
        end
      end
    end
  end

  // One-hot grant vector and winning data word
  always_comb begin
    grant    = '0;
    win_data = '0;
    if (has_grant) grant[gidx] = 1'b1;
    for (int unsigned k = 0; k < CHANNELS; k++) begin
      if (gidx == SELW'(k)) win_data = bus.data_i[k*size +: size];
    end
  end

  assign ptr_nxt = (32'(gidx) == CHANNELS - 1) ? '0 : gidx + 1'b1;
  // Held off while in reset so no channel sees an accept it cannot complete
  assign xfer    = load & has_grant & rst_i;

  assign bus.ready_o = xfer ? grant : '0;
  assign bus.data_o  = data_q;
  assign bus.valid_o = valid_q;
  assign bus.sel_o   = sel_q;

  // Output register and round-robin pointer
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      data_q  <= '0;
      sel_q   <= '0;
      valid_q <= 1'b0;
      ptr_q   <= '0;
    end else if (xfer) begin
      data_q  <= win_data;
      sel_q   <= gidx;
      valid_q <= 1'b1;
      // Forced transfers leave the fairness pointer alone
      if (MODE == 0 && !bus.force_en_i) ptr_q <= ptr_nxt;
    end else if (load) begin
      valid_q <= 1'b0;
    end
  end

endmodule
